amber_core: RTL and testbench
=============================

Name: amber_core

Overview:
- Minimal single-cycle 24-bit CPU core: instruction fetch, decode, execute and writeback all complete in one clock.
- Contains its own word-addressed instruction memory (r_imem) and data memory (r_dmem), a GP register file, address registers, bank registers, flags and a supervisor stack pointer (SSP).
- Top-level compute block; benches preload r_imem hierarchically, release reset and inspect state.

Parameters:
- IMEM_AW, 12, imem index width; index = PC[IMEM_AW-1:0].
- DMEM_AW, 12, dmem index width; index = address[DMEM_AW-1:0].

Ports:
- iw_clk  input  1  clock; all state updates on rising edge.
- iw_rst_n  input  1  asynchronous, active-low reset.
- ow_pc  output  24  current PC.
- ow_halted  output  1  high once SRHLT has executed.

Behaviour:
- State:
  - r_pc[23:0]; r_gp[0..15] DR, 24b; r_ar[0..3], 48b; r_bank[0..2], 12b.
  - r_ssp[23:0]; flags Z, N, C, V; r_halted.
  - Memories r_imem / r_dmem: 24b words, async read, sync write.
- Reset (async, iw_rst_n=0): PC, DRs, ARs, banks, SSP, flags, halted all 0. Memories are not reset. Reset mid-program aborts the current instruction.
- Each cycle when not halted: execute imem[PC], then PC <= PC+1 unless the instruction redirects. Halted: no state changes.
- Encoding: op = instr[23:16].
- Fields:
  - Dn = [15:12] (MOV/ADD/SUB).
  - ARn = [15:14]; MOVAur data register = [13:10]; H = [9].
  - imm12 = [11:0]; imm16 = [15:0]; cc = [15:12].
- Opcodes:
  - 0x10 LUIui: bank[[15:14]] <= imm12 (index 3 ignored).
  - 0x30 MOVsi: Dn <= zext(imm12). Flags unchanged.
  - 0x33 ADDsi: Dn <= Dn + zext(imm12). Sets Z, N, C (carry-out), V.
  - 0x34 SUBsi: Dn <= Dn - zext(imm12). Sets Z, N, C (borrow), V.
  - 0x61 MOVAur: H=0 writes AR[23:0]; H=1 writes AR[47:24]; written from DR[[13:10]].
  - 0xA1 SETSSP: SSP <= AR[[15:14]][23:0].
  - 0x74 BCCso: if cc true, PC <= PC + sext(imm12).
    - cc codes: 0 AL, 1 EQ(Z), 2 NE(!Z), 3 CS, 4 CC, 5 MI, 6 PL, 7 VS, 8 VC; 9-15 never.
  - 0x79 BSRso: push PC+1; PC <= PC + sext(imm16).
  - 0x77 JSRui: push PC+1; PC <= {bank0, imm12}. bank1/bank2 unused for the 24-bit PC.
  - 0x7A RET: SSP <= SSP+1; PC <= dmem[SSP+1].
  - 0xA0 SRHLT: halted <= 1; PC holds.
  - Any other opcode: NOP (PC+1).
- Push: dmem[SSP] <= value; SSP <= SSP-1 (post-decrement). Pop is the exact inverse.
- Arithmetic wraps modulo 2^24. PC wraps at 24 bits. SSP wraps modulo 2^24.

Optional Feature:
- AMBER_HALT_ON_ILLEGAL_EN defined: an undefined opcode sets halted and freezes PC at the illegal instruction.
- Undefined: an undefined opcode is a NOP.

Decomposition:
- Package amber_pkg:
  - opcode localparams (OPC_LUIUI, OPC_MOVSI, OPC_ADDSI, OPC_SUBSI, OPC_MOVAUR, OPC_SETSSP, OPC_BCCSO, OPC_BSRSO, OPC_JSRUI, OPC_RET, OPC_SRHLT);
  - condition-code constants CC_AL..CC_VC;
  - field bit positions.
- One natural sub-module: amber_alu (24b add/sub with Z/N/C/V outputs).

Test Plan:
- Nested call program, run 400 cycles:
  - Program: SSP=0x0FF0 via MOVsi/MOVAur/SETSSP; DR0=5, DR1=1, DR2=2.
  - Loop: BSR +5 to 0x10; SUBsi DR0; BCC NE -2.
  - SUB1 at 0x10: ADD #3 DR1, JSR 0x18, SUB #1 DR2, RET. SUB2 at 0x18: ADD #2 DR1, RET.
  - Required: DR0=000000, DR1=00001A, DR2=FFFFFD, SSP=000FF0, dmem[0FF0]=00000C, dmem[0FEF]=000015, PC=00000E, halted=1.
- MOVAur: DR3=0x123, DR4=0x456, write L then H to AR2 -> AR2=000456_000123; SETSSP AR2 -> SSP=000123.
- BCC not taken: DR0=1, SUB #1 then BCC EQ-fail path sequence -> Z=1; BCC NE falls through to PC+1.
- SUB 0-1: DR=0, SUBsi #1 -> DR=FFFFFF, N=1, C=1, Z=0.
- Reset asserted mid-loop -> PC=0, DRs=0, SSP=0, halted=0 immediately (asynchronous); execution restarts at 0 after release.
- Undefined opcode 0xFF at 0x05 -> NOP (PC 6 next); with AMBER_HALT_ON_ILLEGAL_EN, halted=1 and PC=5.

Source files
------------

// File: rtl/amber_pkg.sv
// Shared definitions for the amber_core CPU: opcodes, condition codes,
// instruction field positions, flag bundle and the branch-condition helper.
package amber_pkg;

    localparam logic [7:0] OPC_LUIUI  = 8'h10;
    localparam logic [7:0] OPC_MOVSI  = 8'h30;
    localparam logic [7:0] OPC_ADDSI  = 8'h33;
    localparam logic [7:0] OPC_SUBSI  = 8'h34;
    localparam logic [7:0] OPC_MOVAUR = 8'h61;
    localparam logic [7:0] OPC_SETSSP = 8'hA1;
    localparam logic [7:0] OPC_BCCSO  = 8'h74;
    localparam logic [7:0] OPC_BSRSO  = 8'h79;
    localparam logic [7:0] OPC_JSRUI  = 8'h77;
    localparam logic [7:0] OPC_RET    = 8'h7A;
    localparam logic [7:0] OPC_SRHLT  = 8'hA0;

    localparam logic [3:0] CC_AL = 4'd0;
    localparam logic [3:0] CC_EQ = 4'd1;
    localparam logic [3:0] CC_NE = 4'd2;
    localparam logic [3:0] CC_CS = 4'd3;
    localparam logic [3:0] CC_CC = 4'd4;
    localparam logic [3:0] CC_MI = 4'd5;
    localparam logic [3:0] CC_PL = 4'd6;
    localparam logic [3:0] CC_VS = 4'd7;
    localparam logic [3:0] CC_VC = 4'd8;

    localparam int unsigned OP_MSB    = 23;
    localparam int unsigned OP_LSB    = 16;
    localparam int unsigned DN_MSB    = 15;
    localparam int unsigned DN_LSB    = 12;
    localparam int unsigned ARN_MSB   = 15;
    localparam int unsigned ARN_LSB   = 14;
    localparam int unsigned MDR_MSB   = 13;
    localparam int unsigned MDR_LSB   = 10;
    localparam int unsigned H_BIT     = 9;
    localparam int unsigned IMM12_MSB = 11;
    localparam int unsigned IMM16_MSB = 15;
    localparam int unsigned CC_MSB    = 15;
    localparam int unsigned CC_LSB    = 12;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

    typedef enum logic {
        ALU_ADD,
        ALU_SUB
    } alu_op_e;

    function automatic logic cc_true(input logic [3:0] cc, input flags_t f);
        logic t;
        case (cc)
            CC_AL:   t = 1'b1;
            CC_EQ:   t = f.z;
            CC_NE:   t = !f.z;
            CC_CS:   t = f.c;
            CC_CC:   t = !f.c;
            CC_MI:   t = f.n;
            CC_PL:   t = !f.n;
            CC_VS:   t = f.v;
            CC_VC:   t = !f.v;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/amber_alu.sv
// 24-bit add/subtract unit producing Z/N/C/V; on subtract C is the borrow.
module amber_alu
    import amber_pkg::*;
(
    input  logic [23:0] a_i,
    input  logic [23:0] b_i,
    input  alu_op_e     op_i,
    output logic [23:0] res_o,
    output flags_t      flags_o
);

    logic [24:0] wide;

    always_comb begin
        if (op_i == ALU_SUB) begin
            wide = {1'b0, a_i} - {1'b0, b_i};
        end else begin
            wide = {1'b0, a_i} + {1'b0, b_i};
        end
        res_o     = wide[23:0];
        flags_o.z = (wide[23:0] == '0);
        flags_o.n = wide[23];
        flags_o.c = wide[24];
        if (op_i == ALU_SUB) begin
            flags_o.v = (a_i[23] != b_i[23]) && (wide[23] != a_i[23]);
        end else begin
            flags_o.v = (a_i[23] == b_i[23]) && (wide[23] != a_i[23]);
        end
    end

endmodule

// File: rtl/amber_core.sv
// Single-cycle 24-bit amber CPU core with internal imem/dmem.
// Define AMBER_HALT_ON_ILLEGAL_EN to halt on undefined opcodes instead of NOP.
module amber_core
    import amber_pkg::*;
#(
    parameter int IMEM_AW = 12,
    parameter int DMEM_AW = 12
) (
    input  logic        iw_clk,
    input  logic        iw_rst_n,
    output logic [23:0] ow_pc,
    output logic        ow_halted
);

    logic [23:0] r_imem [0:(1<<IMEM_AW)-1];
    logic [23:0] r_dmem [0:(1<<DMEM_AW)-1];

    logic [23:0] r_pc;
    logic [23:0] r_gp   [0:15];
    logic [47:0] r_ar   [0:3];
    logic [11:0] r_bank [0:2];
    logic [23:0] r_ssp;
    flags_t      r_flags;
    logic        r_halted;

    logic [23:0] instr;
    logic [7:0]  op;
    logic [3:0]  dn;
    logic [1:0]  arn;
    logic [3:0]  mdr;
    logic        hsel;
    logic [11:0] imm12;
    logic [15:0] imm16;
    logic [3:0]  cc;

    logic [23:0] pc_inc, ret_addr, ret_pc;
    logic [23:0] alu_res;
    flags_t      alu_flags;
    alu_op_e     alu_op;

    logic [23:0] pc_d, ssp_d, gp_wdata, dm_wdata;
    flags_t      flags_d;
    logic        halted_d, gp_we, ar_we, bank_we, dm_we;
    logic [DMEM_AW-1:0] dm_addr;

    assign instr    = r_imem[r_pc[IMEM_AW-1:0]];
    assign op       = instr[OP_MSB:OP_LSB];
    assign dn       = instr[DN_MSB:DN_LSB];
    assign arn      = instr[ARN_MSB:ARN_LSB];
    assign mdr      = instr[MDR_MSB:MDR_LSB];
    assign hsel     = instr[H_BIT];
    assign imm12    = instr[IMM12_MSB:0];
    assign imm16    = instr[IMM16_MSB:0];
    assign cc       = instr[CC_MSB:CC_LSB];
    assign pc_inc   = r_pc + 24'd1;
    assign ret_addr = r_ssp + 24'd1;
    assign ret_pc   = r_dmem[ret_addr[DMEM_AW-1:0]];
    assign alu_op   = (op == OPC_SUBSI) ? ALU_SUB : ALU_ADD;

    amber_alu u_alu (
        .a_i     (r_gp[dn]),
        .b_i     ({12'd0, imm12}),
        .op_i    (alu_op),
        .res_o   (alu_res),
        .flags_o (alu_flags)
    );

    always_comb begin
        pc_d     = pc_inc;
        ssp_d    = r_ssp;
        flags_d  = r_flags;
        halted_d = r_halted;
        gp_we    = 1'b0;
        gp_wdata = alu_res;
        ar_we    = 1'b0;
        bank_we  = 1'b0;
        dm_we    = 1'b0;
        dm_wdata = pc_inc;
        dm_addr  = r_ssp[DMEM_AW-1:0];
        case (op)
            OPC_LUIUI:  bank_we = (arn != 2'd3);
            OPC_MOVSI: begin
                gp_we    = 1'b1;
                gp_wdata = {12'd0, imm12};
            end
            OPC_ADDSI, OPC_SUBSI: begin
                gp_we   = 1'b1;
                flags_d = alu_flags;
            end
            OPC_MOVAUR: ar_we = 1'b1;
            OPC_SETSSP: ssp_d = r_ar[arn][23:0];
            OPC_BCCSO: begin
                if (cc_true(cc, r_flags)) pc_d = r_pc + {{12{imm12[11]}}, imm12};
            end
            OPC_BSRSO: begin
                dm_we = 1'b1;
                ssp_d = r_ssp - 24'd1;
                pc_d  = r_pc + {{8{imm16[15]}}, imm16};
            end
            OPC_JSRUI: begin
                dm_we = 1'b1;
                ssp_d = r_ssp - 24'd1;
                pc_d  = {r_bank[0], imm12};
            end
            OPC_RET: begin
                ssp_d = ret_addr;
                pc_d  = ret_pc;
            end
            OPC_SRHLT: begin
                halted_d = 1'b1;
                pc_d     = r_pc;
            end
            default: begin
`ifdef AMBER_HALT_ON_ILLEGAL_EN
                halted_d = 1'b1;
                pc_d     = r_pc;
`endif
            end
        endcase
    end

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            r_pc     <= '0;
            r_ssp    <= '0;
            r_flags  <= '0;
            r_halted <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) r_gp[i] <= '0;
            for (int unsigned i = 0; i < 4; i++) r_ar[i] <= '0;
            for (int unsigned i = 0; i < 3; i++) r_bank[i] <= '0;
        end else if (!r_halted) begin
            r_pc     <= pc_d;
            r_ssp    <= ssp_d;
            r_flags  <= flags_d;
            r_halted <= halted_d;
            if (gp_we) r_gp[dn] <= gp_wdata;
            if (ar_we) begin
                if (hsel) r_ar[arn][47:24] <= r_gp[mdr];
                else      r_ar[arn][23:0]  <= r_gp[mdr];
            end
            // bank index 3 has no register, so the write is simply dropped
            for (int unsigned i = 0; i < 3; i++) begin
                if (bank_we && (arn == i[1:0])) r_bank[i] <= imm12;
            end
        end
    end

    // Memory has no reset; the rst_n term keeps an aborted push from landing.
    always_ff @(posedge iw_clk) begin
        if (dm_we && !r_halted && iw_rst_n) r_dmem[dm_addr] <= dm_wdata;
    end

    assign ow_pc     = r_pc;
    assign ow_halted = r_halted;

endmodule

// File: tb/tb_amber_core.sv
// Self-checking bench for amber_core: directed programs plus random
// instruction streams compared against an arithmetic reference model.
module tb_amber_core;
    import amber_pkg::*;

    localparam int DEPTH = 4096;
    localparam int M24   = 1 << 24;
    localparam bit [23:0] FILL = 24'h74F000; // BCC "never": a defined no-op
    localparam bit [23:0] HLT  = 24'hA00000;
    localparam bit [23:0] RETI = 24'h7A0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] pc;
    logic        halted;

    amber_core #(.IMEM_AW(12), .DMEM_AW(12)) dut (
        .iw_clk    (clk),
        .iw_rst_n  (rst_n),
        .ow_pc     (pc),
        .ow_halted (halted)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model state
    bit [23:0] img    [DEPTH];
    bit [23:0] m_imem [DEPTH];
    bit [23:0] m_dmem [int];
    int        m_pc, m_ssp;
    int        m_gp   [16];
    bit [47:0] m_ar   [4];
    int        m_bank [3];
    bit        m_z, m_n, m_c, m_v, m_halt;

    function automatic int sx(input int v, input int bits);
        return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
    endfunction

    function automatic int wrap(input int v);
        return ((v % M24) + M24) % M24;
    endfunction

    function automatic bit cond(input int c);
        case (c)
            0: return 1'b1;
            1: return m_z;
            2: return !m_z;
            3: return m_c;
            4: return !m_c;
            5: return m_n;
            6: return !m_n;
            7: return m_v;
            8: return !m_v;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void push(input int v);
        m_dmem[m_ssp % DEPTH] = 24'(v);
        m_ssp = wrap(m_ssp - 1);
    endfunction

    function automatic void arith(input int d, input int imm, input bit sub);
        int a = m_gp[d];
        int r = sub ? a - imm : a + imm;
        int s = sub ? sx(a, 24) - imm : sx(a, 24) + imm;
        m_gp[d] = wrap(r);
        m_c = sub ? (r < 0) : (r >= M24);
        m_v = (s >= (1 << 23)) || (s < -(1 << 23));
        m_z = (m_gp[d] == 0);
        m_n = (m_gp[d] >= (1 << 23));
    endfunction

    function automatic void model_reset();
        m_pc = 0; m_ssp = 0; m_halt = 0;
        m_z = 0; m_n = 0; m_c = 0; m_v = 0;
        for (int i = 0; i < 16; i++) m_gp[i] = 0;
        for (int i = 0; i < 4; i++) m_ar[i] = '0;
        for (int i = 0; i < 3; i++) m_bank[i] = 0;
    endfunction

    function automatic void model_step();
        bit [23:0] ins;
        int op, hi4, imm12, f16, arn, mdr, nxt;
        if (m_halt) return;
        ins   = m_imem[m_pc % DEPTH];
        op    = int'(ins[23:16]);
        hi4   = int'(ins[15:12]);
        arn   = int'(ins[15:14]);
        mdr   = int'(ins[13:10]);
        imm12 = int'(ins[11:0]);
        f16   = int'(ins[15:0]);
        nxt   = wrap(m_pc + 1);
        case (op)
            'h10: if (arn < 3) m_bank[arn] = imm12;
            'h30: m_gp[hi4] = imm12;
            'h33: arith(hi4, imm12, 1'b0);
            'h34: arith(hi4, imm12, 1'b1);
            'h61: if (ins[9]) m_ar[arn][47:24] = 24'(m_gp[mdr]);
                  else        m_ar[arn][23:0]  = 24'(m_gp[mdr]);
            'hA1: m_ssp = int'(m_ar[arn][23:0]);
            'h74: if (cond(hi4)) nxt = wrap(m_pc + sx(imm12, 12));
            'h79: begin push(wrap(m_pc + 1)); nxt = wrap(m_pc + sx(f16, 16)); end
            'h77: begin push(wrap(m_pc + 1)); nxt = m_bank[0] * 4096 + imm12; end
            'h7A: begin
                m_ssp = wrap(m_ssp + 1);
                nxt = m_dmem.exists(m_ssp % DEPTH) ? int'(m_dmem[m_ssp % DEPTH]) : 0;
            end
            'hA0: begin m_halt = 1; nxt = m_pc; end
            default: begin
`ifdef AMBER_HALT_ON_ILLEGAL_EN
                m_halt = 1; nxt = m_pc;
`endif
            end
        endcase
        m_pc = nxt;
    endfunction

    function automatic bit [23:0] e_mov(input int d, input int imm); return {8'h30, 4'(d), 12'(imm)}; endfunction
    function automatic bit [23:0] e_add(input int d, input int imm); return {8'h33, 4'(d), 12'(imm)}; endfunction
    function automatic bit [23:0] e_sub(input int d, input int imm); return {8'h34, 4'(d), 12'(imm)}; endfunction
    function automatic bit [23:0] e_mova(input int ar, input int d, input int h); return {8'h61, 2'(ar), 4'(d), 1'(h), 9'd0}; endfunction
    function automatic bit [23:0] e_setssp(input int ar); return {8'hA1, 2'(ar), 14'd0}; endfunction
    function automatic bit [23:0] e_bcc(input int c, input int off); return {8'h74, 4'(c), 12'(off)}; endfunction
    function automatic bit [23:0] e_bsr(input int off); return {8'h79, 16'(off)}; endfunction
    function automatic bit [23:0] e_jsr(input int a); return {8'h77, 4'd0, 12'(a)}; endfunction

    function automatic bit is_defined(input int op);
        return op inside {'h10, 'h30, 'h33, 'h34, 'h61, 'hA1, 'h74, 'h79, 'h77, 'h7A, 'hA0};
    endfunction

    function automatic bit [23:0] rand_instr();
        int k   = $urandom_range(0, 11);
        int d   = $urandom_range(0, 15);
        int imm = $urandom_range(0, 4095);
        int ar  = $urandom_range(0, 3);
        int off = $urandom_range(0, 16) - 8;
        int op;
        case (k)
            0:  return e_mov(d, imm);
            1, 11: return e_add(d, imm);
            2:  return e_sub(d, imm);
            3:  return {8'h10, 2'(ar), 2'd0, 12'(imm)};
            4:  return e_mova(ar, d, $urandom_range(0, 1));
            5:  return e_setssp(ar);
            6:  return e_bcc(d, off);
            7:  return e_bsr(off);
            8:  return e_jsr(imm);
            9: begin
                do op = $urandom_range(0, 255); while (is_defined(op));
                return {8'(op), 16'($urandom_range(0, 65535))};
            end
            default: return ($urandom_range(0, 3) == 0) ? HLT : e_mov(d, imm);
        endcase
    endfunction

    function automatic void clear_img();
        for (int i = 0; i < DEPTH; i++) img[i] = FILL;
    endfunction

    task automatic start();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            dut.r_imem[i] = img[i];
            m_imem[i]     = img[i];
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run(input int cycles, input bit stop_on_halt);
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check("pc", pc, 64'(m_pc));
            check("halted", halted, 64'(m_halt));
            if (stop_on_halt && m_halt) break;
        end
    endtask

    task automatic compare_state(input string tag);
        flags_t f;
        f = dut.r_flags;
        for (int i = 0; i < 16; i++) check($sformatf("%s.d%0d", tag, i), dut.r_gp[i], 64'(m_gp[i]));
        for (int i = 0; i < 4; i++) check($sformatf("%s.ar%0d", tag, i), dut.r_ar[i], 64'(m_ar[i]));
        for (int i = 0; i < 3; i++) check($sformatf("%s.bank%0d", tag, i), dut.r_bank[i], 64'(m_bank[i]));
        check({tag, ".ssp"}, dut.r_ssp, 64'(m_ssp));
        check({tag, ".flags"}, {f.z, f.n, f.c, f.v}, {m_z, m_n, m_c, m_v});
        foreach (m_dmem[a]) check($sformatf("%s.dmem%0h", tag, a), dut.r_dmem[a], 64'(m_dmem[a]));
    endtask

    task automatic check_nested(input string tag);
        check({tag, ".d0"}, dut.r_gp[0], 24'h000000);
        check({tag, ".d1"}, dut.r_gp[1], 24'h00001A);
        check({tag, ".d2"}, dut.r_gp[2], 24'hFFFFFD);
        check({tag, ".ssp"}, dut.r_ssp, 24'h000FF0);
        check({tag, ".m0FF0"}, dut.r_dmem[12'hFF0], 24'h00000C);
        check({tag, ".m0FEF"}, dut.r_dmem[12'hFEF], 24'h000015);
        check({tag, ".pc"}, pc, 24'h00000E);
        check({tag, ".halted"}, halted, 1'b1);
    endtask

    function automatic void nested_prog();
        clear_img();
        img[0]     = e_mov(0, 'hFF0);
        img[1]     = e_mova(0, 0, 0);
        img[2]     = e_setssp(0);
        img[3]     = e_mov(0, 5);
        img[4]     = e_mov(1, 1);
        img[5]     = e_mov(2, 2);
        img['h0B]  = e_bsr(5);
        img['h0C]  = e_sub(0, 1);
        img['h0D]  = e_bcc(2, -2);
        img['h0E]  = HLT;
        img['h10]  = e_add(1, 3);
        img['h14]  = e_jsr('h18);
        img['h15]  = e_sub(2, 1);
        img['h16]  = RETI;
        img['h18]  = e_add(1, 2);
        img['h19]  = RETI;
    endfunction

    initial begin
        flags_t f;

        // nested calls
        nested_prog();
        start();
        run(400, 1'b1);
        check_nested("nest");
        compare_state("nest");

        // asynchronous reset in the middle of the loop, then restart
        nested_prog();
        start();
        run(30, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("rst.pc", pc, 24'h0);
        check("rst.d0", dut.r_gp[0], 24'h0);
        check("rst.d1", dut.r_gp[1], 24'h0);
        check("rst.ssp", dut.r_ssp, 24'h0);
        check("rst.halted", halted, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run(400, 1'b1);
        check_nested("rerun");

        // MOVAur low/high then SETSSP
        clear_img();
        img[0] = e_mov(3, 'h123);
        img[1] = e_mov(4, 'h456);
        img[2] = e_mova(2, 3, 0);
        img[3] = e_mova(2, 4, 1);
        img[4] = e_setssp(2);
        img[5] = HLT;
        start();
        run(20, 1'b1);
        check("mova.ar2", dut.r_ar[2], 48'h000456_000123);
        check("mova.ssp", dut.r_ssp, 24'h000123);
        check("mova.halted", halted, 1'b1);

        // BCC NE not taken after a zero result
        clear_img();
        img[0] = e_mov(0, 1);
        img[1] = e_sub(0, 1);
        img[2] = e_bcc(2, 5);
        img[3] = HLT;
        start();
        run(20, 1'b1);
        f = dut.r_flags;
        check("bcc.z", f.z, 1'b1);
        check("bcc.pc", pc, 24'h3);
        check("bcc.halted", halted, 1'b1);

        // 0 - 1 wraps with borrow
        clear_img();
        img[0] = e_mov(5, 0);
        img[1] = e_sub(5, 1);
        img[2] = HLT;
        start();
        run(20, 1'b1);
        f = dut.r_flags;
        check("sub0.d5", dut.r_gp[5], 24'hFFFFFF);
        check("sub0.nczv", {f.n, f.c, f.z, f.v}, 4'b1100);

        // undefined opcode at 0x05
        clear_img();
        img[5] = 24'hFF0000;
        img[6] = HLT;
        start();
        run(20, 1'b1);
`ifdef AMBER_HALT_ON_ILLEGAL_EN
        check("undef.pc", pc, 24'h5);
`else
        check("undef.pc", pc, 24'h6);
`endif
        check("undef.halted", halted, 1'b1);

        // random instruction streams
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < DEPTH; i++) img[i] = rand_instr();
            start();
            run(250, 1'b0);
            compare_state($sformatf("rnd%0d", p));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
